// File: rtl/acl_spi_sequencer.sv
// Autonomous ADXL362 SPI sequencer: one POWER_CTL write after reset, then periodic XYZ burst reads.
// Define ACL_TEMP_READ_EN to extend the burst with TEMP_L/TEMP_H and add the temp_o port.
module acl_spi_sequencer #(
    parameter int CLK_DIV       = 10,
    parameter int SAMPLE_PERIOD = 500000,
    parameter int CS_GAP        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        acl_miso,
    output logic        acl_mosi,
    output logic        acl_sclk,
    output logic        acl_csn,
    output logic [15:0] x_o,
    output logic [15:0] y_o,
    output logic [15:0] z_o,
`ifdef ACL_TEMP_READ_EN
    output logic [15:0] temp_o,
`endif
    output logic        valid_o,
    output logic        busy_o,
    output logic        cfg_done_o,
    output logic [15:0] sample_cnt_o
);
`ifdef ACL_TEMP_READ_EN
    localparam int DUMMY_BYTES = 8;
`else
    localparam int DUMMY_BYTES = 6;
`endif
    localparam int RD_BITS  = 8 * (2 + DUMMY_BYTES);
    localparam int CFG_BITS = 24;
    localparam int RX_W     = 8 * DUMMY_BYTES;
    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int BIT_W    = $clog2(RD_BITS);
    localparam int PER_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0]   PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [RD_BITS-1:0] CFG_TX   = {24'h0A2D02, {(RD_BITS - CFG_BITS){1'b0}}};
    localparam logic [RD_BITS-1:0] RD_TX    = {16'h0B0E, {RX_W{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_GAP, S_WAIT, S_READ, S_UPD} state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div_cnt;
    logic               phase;      // 0: SCLK low half, 1: SCLK high half
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_last;
    logic [RD_BITS-1:0] tx_sr;
    logic [RX_W-1:0]    rx_sr;
    logic [PER_W-1:0]   per_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic in_frame, half_done, frame_end, per_done, start_cfg, start_read;

    assign in_frame   = (state == S_CFG) || (state == S_READ);
    assign half_done  = in_frame && (div_cnt == DIV_LAST);
    assign frame_end  = half_done && phase && (bit_cnt == bit_last);
    assign per_done   = (per_cnt == PER_LAST);
    assign start_cfg  = (state == S_IDLE) && enable_i && !cfg_done_o;
    assign start_read = (state == S_WAIT) && enable_i && per_done;
    assign busy_o     = !acl_csn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (enable_i) state_n = cfg_done_o ? S_WAIT : S_CFG;
            S_CFG:  if (frame_end) state_n = S_GAP;
            S_GAP:  if (gap_cnt == GAP_LAST) state_n = enable_i ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!enable_i)    state_n = S_IDLE;
                else if (per_done) state_n = S_READ;
            end
            S_READ: if (frame_end) state_n = S_UPD;
            S_UPD:  state_n = S_GAP;
            default: state_n = S_IDLE;
        endcase
    end

    // Period counter saturates so a long frame never queues a backlog of reads;
    // idling and config completion both leave it saturated so the next read is immediate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= PER_LAST;
            gap_cnt <= '0;
        end else begin
            if (start_read)
                per_cnt <= '0;
            else if (state == S_IDLE || (state == S_CFG && frame_end))
                per_cnt <= PER_LAST;
            else if (!per_done)
                per_cnt <= per_cnt + 1'b1;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acl_csn      <= 1'b1;
            acl_sclk     <= 1'b0;
            acl_mosi     <= 1'b0;
            div_cnt      <= '0;
            phase        <= 1'b0;
            bit_cnt      <= '0;
            bit_last     <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            x_o          <= '0;
            y_o          <= '0;
            z_o          <= '0;
`ifdef ACL_TEMP_READ_EN
            temp_o       <= '0;
`endif
            valid_o      <= 1'b0;
            cfg_done_o   <= 1'b0;
            sample_cnt_o <= '0;
        end else begin
            valid_o <= 1'b0;
            if (start_cfg || start_read) begin
                acl_csn  <= 1'b0;
                acl_sclk <= 1'b0;
                div_cnt  <= '0;
                phase    <= 1'b0;
                bit_cnt  <= '0;
                if (start_cfg) begin
                    acl_mosi <= CFG_TX[RD_BITS-1];
                    tx_sr    <= CFG_TX << 1;
                    bit_last <= BIT_W'(CFG_BITS - 1);
                end else begin
                    acl_mosi <= RD_TX[RD_BITS-1];
                    tx_sr    <= RD_TX << 1;
                    bit_last <= BIT_W'(RD_BITS - 1);
                end
            end else if (in_frame) begin
                if (half_done) begin
                    div_cnt <= '0;
                    phase   <= ~phase;
                    if (!phase) begin
                        acl_sclk <= 1'b1;
                        rx_sr    <= {rx_sr[RX_W-2:0], acl_miso};
                    end else begin
                        acl_sclk <= 1'b0;
                        if (frame_end) begin
                            acl_csn  <= 1'b1;
                            acl_mosi <= 1'b0;
                            if (state == S_CFG) begin
                                cfg_done_o <= 1'b1;
                            end else begin
                                // Burst order is XL,XH,YL,YH,ZL,ZH[,TL,TH], oldest byte in the MSBs.
                                x_o          <= {rx_sr[RX_W-9  -: 8], rx_sr[RX_W-1  -: 8]};
                                y_o          <= {rx_sr[RX_W-25 -: 8], rx_sr[RX_W-17 -: 8]};
                                z_o          <= {rx_sr[RX_W-41 -: 8], rx_sr[RX_W-33 -: 8]};
`ifdef ACL_TEMP_READ_EN
                                temp_o       <= {rx_sr[RX_W-57 -: 8], rx_sr[RX_W-49 -: 8]};
`endif
                                valid_o      <= 1'b1;
                                sample_cnt_o <= sample_cnt_o + 16'd1;
                            end
                        end else begin
                            acl_mosi <= tx_sr[RD_BITS-1];
                            tx_sr    <= tx_sr << 1;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_acl_spi_sequencer.sv
// Bench for acl_spi_sequencer: ADXL362 bus model, frame-level reference model, random register data and enable.
module tb_acl_spi_sequencer;
    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 2000;
    localparam int CS_GAP        = 4;
`ifdef ACL_TEMP_READ_EN
    localparam int RD_BYTES = 10;
`else
    localparam int RD_BYTES = 8;
`endif

    logic        clk = 1'b0, rst = 1'b0, enable_i = 1'b0, acl_miso = 1'b0;
    logic        acl_mosi, acl_sclk, acl_csn, valid_o, busy_o, cfg_done_o;
    logic [15:0] x_o, y_o, z_o, sample_cnt_o;
`ifdef ACL_TEMP_READ_EN
    logic [15:0] temp_o;
`endif
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    acl_spi_sequencer #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .acl_miso(acl_miso),
        .acl_mosi(acl_mosi), .acl_sclk(acl_sclk), .acl_csn(acl_csn),
        .x_o(x_o), .y_o(y_o), .z_o(z_o),
`ifdef ACL_TEMP_READ_EN
        .temp_o(temp_o),
`endif
        .valid_o(valid_o), .busy_o(busy_o), .cfg_done_o(cfg_done_o), .sample_cnt_o(sample_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input bit cfg, input int i);
        if (cfg) return (i == 0) ? 8'h0A : (i == 1) ? 8'h2D : 8'h02;
        return (i == 0) ? 8'h0B : (i == 1) ? 8'h0E : 8'h00;
    endfunction

    // ADXL362 bus model: register file, MOSI capture on SCLK rise, MISO shifted on SCLK fall.
    logic [7:0] regs [0:63];
    logic [7:0] fbytes [$];
    int         bitn;
    logic [7:0] sh, cmd, addr, outb;

    always @(negedge acl_csn) begin
        bitn = 0; fbytes.delete(); outb = 8'h00; cmd = 8'h00; acl_miso = 1'b0;
    end
    always @(posedge acl_sclk) if (!acl_csn) begin
        sh = {sh[6:0], acl_mosi};
        bitn++;
        if (bitn % 8 == 0) begin
            fbytes.push_back(sh);
            if (bitn == 8)  cmd  = sh;
            if (bitn == 16) addr = sh;
        end
    end
    always @(negedge acl_sclk) if (!acl_csn) begin
        if (bitn >= 16 && bitn % 8 == 0 && cmd == 8'h0B) begin
            outb = regs[addr[5:0]];
            addr = addr + 8'd1;
        end else begin
            outb = {outb[6:0], 1'b0};
        end
        acl_miso = outb[7];
    end

    // Frame-level reference model and per-cycle compare.
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          m_cfg_done, fr_cfg, prev_was_cfg, prev_rd_ok, en_steady, en_since_rise, have_rise, first_rise, exp_valid;
    int          m_cnt, fall_cyc, rise_cyc, prev_rd_fall, last_en_cyc, last_sclk_rise, nb;
    int          n_falls = 0, n_rises = 0, n_valid = 0, last_len = 0;
    logic [15:0] mx, my, mz, mt, sx, sy, sz, st;
    logic [7:0]  last_bytes [$];
    logic        p_csn = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;

    always @(negedge clk) begin
        exp_valid = 1'b0;
        if (rst) begin
            m_cfg_done = 0; m_cnt = 0; mx = '0; my = '0; mz = '0; mt = '0;
            prev_rd_ok = 0; have_rise = 0; prev_was_cfg = 0; en_steady = 0;
            chk("rst_csn", acl_csn, 1);  chk("rst_sclk", acl_sclk, 0);
            chk("rst_mosi", acl_mosi, 0); chk("rst_valid", valid_o, 0);
            chk("rst_cnt", sample_cnt_o, 0); chk("rst_cfg_done", cfg_done_o, 0);
        end else begin
            if (enable_i) last_en_cyc = cyc;
            else begin en_steady = 0; en_since_rise = 0; end
            if (p_csn && !acl_csn) begin
                n_falls++; fall_cyc = cyc; first_rise = 1; fr_cfg = !m_cfg_done;
                sx = {regs[15], regs[14]}; sy = {regs[17], regs[16]};
                sz = {regs[19], regs[18]}; st = {regs[21], regs[20]};
                chk("start_needs_enable", (cyc - last_en_cyc) <= 3, 1);
                if (have_rise) chk("csn_gap_min", (cyc - rise_cyc) >= CS_GAP, 1);
                if (!fr_cfg) begin
                    if (prev_rd_ok && en_steady) chk("read_period", cyc - prev_rd_fall, SAMPLE_PERIOD);
                    if (prev_was_cfg && en_since_rise) chk("read_after_cfg", (cyc - rise_cyc) <= CS_GAP + 3, 1);
                    prev_rd_fall = cyc; prev_rd_ok = 1; en_steady = 1;
                end
            end
            if (!p_sclk && acl_sclk) begin
                chk("mosi_stable_rise", acl_mosi, p_mosi);
                if (first_rise) chk("first_rise_delay", cyc - fall_cyc, CLK_DIV);
                else            chk("sclk_period", cyc - last_sclk_rise, 2 * CLK_DIV);
                first_rise = 0; last_sclk_rise = cyc;
            end
            if (!p_csn && acl_csn) begin
                n_rises++; rise_cyc = cyc; have_rise = 1; en_since_rise = enable_i;
                nb = fr_cfg ? 3 : RD_BYTES;
                chk("csn_low_len", cyc - fall_cyc, 16 * CLK_DIV * nb);
                chk("sclk_fall_at_csn_rise", p_sclk, 1);
                chk("frame_nbytes", fbytes.size(), nb);
                for (int i = 0; i < fbytes.size() && i < nb; i++) chk("mosi_byte", fbytes[i], exp_byte(fr_cfg, i));
                last_bytes = fbytes; last_len = cyc - fall_cyc; prev_was_cfg = fr_cfg;
                if (fr_cfg) m_cfg_done = 1;
                else begin
                    mx = sx; my = sy; mz = sz; mt = st;
                    m_cnt = (m_cnt + 1) & 16'hFFFF; exp_valid = 1'b1;
                end
            end
            if (acl_csn) chk("sclk_idle_low", acl_sclk, 0);
            if (valid_o) n_valid++;
            chk("busy", busy_o, !acl_csn);
            chk("valid", valid_o, exp_valid);
            chk("cfg_done", cfg_done_o, m_cfg_done);
            chk("x", x_o, mx); chk("y", y_o, my); chk("z", z_o, mz);
`ifdef ACL_TEMP_READ_EN
            chk("temp", temp_o, mt);
`endif
            chk("sample_cnt", sample_cnt_o, m_cnt);
        end
        p_csn = acl_csn; p_sclk = acl_sclk; p_mosi = acl_mosi;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input int lim);
        int start = n_falls;
        int k = 0;
        while (n_falls == start && k < lim) begin @(posedge clk); k++; end
        #1;
        if (n_falls == start) begin n_tests++; n_fail++; $display("FAIL timeout_csn_fall: none within %0d cycles", lim); end
    endtask

    task automatic wait_rise(input int lim);
        int start = n_rises;
        int k = 0;
        while (n_rises == start && k < lim) begin @(posedge clk); k++; end
        #1;
        if (n_rises == start) begin n_tests++; n_fail++; $display("FAIL timeout_csn_rise: none within %0d cycles", lim); end
    endtask

    task automatic rand_xyz();
        for (int i = 14; i < 22; i++) regs[i] = 8'($urandom);
    endtask

    int f0, v0;

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 8'($urandom);
        #1 rst = 1'b1;
        tick(3);
        chk("lit_reset_csn", acl_csn, 1); chk("lit_reset_busy", busy_o, 0);
        chk("lit_reset_x", x_o, 0);       chk("lit_reset_cfg", cfg_done_o, 0);

        // Config frame
        rst = 1'b0; enable_i = 1'b1;
        wait_fall(20);
        wait_rise(200);
        regs[14] = 8'h23; regs[15] = 8'h01; regs[16] = 8'h85; regs[17] = 8'hFF;
        regs[18] = 8'h00; regs[19] = 8'h04; regs[20] = 8'h10; regs[21] = 8'h02;
        chk("lit_cfg_len", last_len, 96);
        chk("lit_cfg_nbytes", last_bytes.size(), 3);
        if (last_bytes.size() == 3) begin
            chk("lit_cfg_b0", last_bytes[0], 8'h0A);
            chk("lit_cfg_b1", last_bytes[1], 8'h2D);
            chk("lit_cfg_b2", last_bytes[2], 8'h02);
        end
        chk("lit_cfg_done", cfg_done_o, 1);
        chk("lit_cfg_no_valid", n_valid, 0);

        // First read with known sample
        wait_fall(50);
        wait_rise(400);
        tick(1);
        chk("lit_x", x_o, 16'h0123); chk("lit_y", y_o, 16'hFF85); chk("lit_z", z_o, 16'h0400);
`ifdef ACL_TEMP_READ_EN
        chk("lit_temp", temp_o, 16'h0210);
        chk("lit_read_len", last_len, 320);
`else
        chk("lit_read_len", last_len, 256);
`endif
        chk("lit_cnt", sample_cnt_o, 1);
        chk("lit_valid_pulses", n_valid, 1);
        chk("lit_read_b0", last_bytes[0], 8'h0B);
        chk("lit_read_b1", last_bytes[1], 8'h0E);

        // Free run with random samples
        for (int n = 0; n < 5; n++) begin
            rand_xyz();
            wait_fall(2100);
            wait_rise(400);
        end
        chk("lit_free_run_valids", n_valid, 6);

        // Disable in byte 4 of a read
        rand_xyz();
        wait_fall(2100);
        tick(4 * 16 * CLK_DIV);
        v0 = n_valid;
        enable_i = 1'b0;
        wait_rise(400);
        tick(2);
        chk("disable_frame_valid", n_valid, v0 + 1);
        f0 = n_falls;
        tick(3000);
        chk("disable_no_frames", n_falls, f0);
        chk("disable_busy", busy_o, 0);
        chk("disable_csn", acl_csn, 1);
        enable_i = 1'b1;
        wait_fall(5);
        wait_rise(400);
        chk("reenable_read_b0", last_bytes[0], 8'h0B);
        chk("reenable_cfg_done", cfg_done_o, 1);

        // Random enable activity
        for (int n = 0; n < 4; n++) begin
            rand_xyz();
            tick($urandom_range(50, 2500));
            enable_i = 1'($urandom_range(0, 1));
        end
        enable_i = 1'b1;

        // Reset in the middle of a read
        wait_fall(2100);
        tick($urandom_range(20, 200));
        rst = 1'b1;
        #1;
        chk("midrst_csn", acl_csn, 1);  chk("midrst_sclk", acl_sclk, 0);
        chk("midrst_busy", busy_o, 0);  chk("midrst_x", x_o, 0);
        chk("midrst_cnt", sample_cnt_o, 0); chk("midrst_cfg", cfg_done_o, 0);
        tick(3);
        rst = 1'b0;
        wait_fall(20);
        wait_rise(200);
        chk("midrst_recfg_b0", last_bytes[0], 8'h0A);
        chk("midrst_recfg_len", last_len, 96);
        rand_xyz();
        wait_fall(50);
        wait_rise(400);
        tick(2);
        chk("midrst_cnt_after", sample_cnt_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
